// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cbus types plus arbiter state encoding and counter width.
// Used by cbus_rr_arbiter and rr_picker.
package cbus_rr_arbiter_pkg;

  localparam int CBUS_ADDR_W    = 32;
  localparam int CBUS_DATA_W    = 32;
  localparam int CBUS_LEN_W     = 8;
  localparam int CBUS_ARB_CNT_W = 32;

  typedef struct packed {
    logic                     valid;
    logic                     is_write;
    logic [2:0]               size;
    logic [CBUS_ADDR_W-1:0]   addr;
    logic [CBUS_DATA_W/8-1:0] strobe;
    logic [CBUS_DATA_W-1:0]   data;
    logic [CBUS_LEN_W-1:0]    len;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } cbus_arb_state_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index at or after prio,
// wrapping modulo NUM_INPUTS.
module rr_picker
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  localparam int IDX_W = idx_w(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [IDX_W-1:0]      prio,
  output logic                  found,
  output logic [IDX_W-1:0]      idx
);

  int j;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      j = (int'(prio) + k) % NUM_INPUTS;
      if (valid[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin cbus arbiter holding each grant for a whole burst.
// CBUS_ARB_STATS_EN adds per-master completed-burst counters (grant_cnt).
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  cbus_req_t  [NUM_INPUTS-1:0]   ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]   iresps,
  output cbus_req_t                     oreq,
  input  cbus_resp_t                    oresp
`ifdef CBUS_ARB_STATS_EN
  ,
  output logic [NUM_INPUTS-1:0][CBUS_ARB_CNT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W = idx_w(NUM_INPUTS);

  cbus_arb_state_t  state, state_d;
  logic [IDX_W-1:0] sel, sel_d;
  logic [IDX_W-1:0] prio, prio_d;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] next_prio;
  logic [NUM_INPUTS-1:0] req_valid;
  logic found;
  logic cur_valid;
  logic done;
  logic abort;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      req_valid[i] = ireqs[i].valid;
    end
  end

  rr_picker #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_pick (
    .valid (req_valid),
    .prio  (prio),
    .found (found),
    .idx   (pick)
  );

  assign cur_valid = ireqs[sel].valid;
  assign done  = (state == BUSY) & cur_valid & oresp.ready & oresp.last;
  assign abort = (state == BUSY) & ~cur_valid;
  assign next_prio = (int'(sel) == NUM_INPUTS - 1) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      prio  <= '0;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      prio  <= prio_d;
    end
  end

  // Outputs depend only on registered grant: no ireqs->oreq path in IDLE.
  always_comb begin
    state_d = state;
    sel_d   = sel;
    prio_d  = prio;
    oreq    = '0;
    iresps  = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        oreq        = ireqs[sel];
        iresps[sel] = oresp;
        if (done || abort) begin
          state_d = IDLE;
          prio_d  = next_prio;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CBUS_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt <= '0;
    end else if (done) begin
      grant_cnt[sel] <= grant_cnt[sel] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter (NUM_INPUTS=2).
// Counter checks are active when CBUS_ARB_STATS_EN is defined.
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  cbus_req_t  [1:0] ireqs;
  cbus_resp_t [1:0] iresps;
  cbus_req_t  oreq;
  cbus_resp_t oresp;
`ifdef CBUS_ARB_STATS_EN
  logic [1:0][31:0] grant_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int nrdy;
  int lastb;
  bit done_flag = 1'b0;
  logic [31:0] exp_cnt0;
  logic [31:0] exp_cnt1;
  cbus_req_t r0;
  cbus_req_t r1;

  always #5 clk = ~clk;

  cbus_rr_arbiter #(
    .NUM_INPUTS (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
`ifdef CBUS_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, want);
    end
  endtask

  initial begin
    #100000;
    if (!done_flag) begin
      failures++;
      $error("FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
    end
  end

  function automatic cbus_req_t mk_req(logic w, logic [31:0] a,
                                       logic [7:0] l);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = w;
    r.size     = 3'd2;
    r.addr     = a;
    r.strobe   = w ? 4'hf : 4'h0;
    r.data     = w ? (32'hd00d_0000 | a) : 32'h0;
    r.len      = l;
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(logic rdy, logic lst,
                                         logic [31:0] d);
    cbus_resp_t p;
    p.ready = rdy;
    p.last  = lst;
    p.data  = d;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  initial begin
    ireqs    = '0;
    oresp    = '0;
    exp_cnt0 = '0;
    exp_cnt1 = '0;

    // Reset state
    tick();
    probe();
    chk("rst_oreq", oreq, '0);
    chk("rst_iresps", iresps, '0);
    chk("rst_prio", dut.prio, 1'b0);
    chk("rst_sel", dut.sel, 1'b0);
`ifdef CBUS_ARB_STATS_EN
    chk("rst_cnt", grant_cnt, '0);
`endif

    // Single ICache read, 16 beats
    tick();
    reset = 1'b0;
    tick();
    r0 = mk_req(1'b0, 32'h1000, 8'd15);
    ireqs[0] = r0;
    probe();
    chk("t1_no_comb", oreq.valid, 1'b0);
    nrdy = 0;
    lastb = -1;
    for (int b = 0; b < 16; b++) begin
      tick();
      oresp = mk_resp(1'b1, b == 15, 32'(b) + 32'h100);
      probe();
      chk("t1_oreq", oreq, r0);
      chk("t1_iresp0", iresps[0], oresp);
      chk("t1_iresp1", iresps[1], '0);
      if (iresps[0].ready) nrdy++;
      if (iresps[0].last && lastb < 0) lastb = b;
    end
    chk("t1_beats", nrdy, 16);
    chk("t1_lastbeat", lastb, 15);
    tick();
    ireqs[0] = '0;
    oresp = '0;
    probe();
    chk("t1_idle", oreq.valid, 1'b0);
    chk("t1_prio", dut.prio, 1'b1);
    chk("t1_state", dut.state, IDLE);
    exp_cnt0++;
`ifdef CBUS_ARB_STATS_EN
    chk("t1_cnt0", grant_cnt[0], exp_cnt0);
`endif

    // Both valid at reset release
    reset = 1'b1;
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    tick();
    tick();
    reset = 1'b0;
    r0 = mk_req(1'b0, 32'h2000, 8'd1);
    r1 = mk_req(1'b1, 32'h3000, 8'd0);
    ireqs[0] = r0;
    ireqs[1] = r1;
    probe();
    chk("t2_no_comb", oreq.valid, 1'b0);
    for (int b = 0; b < 2; b++) begin
      tick();
      oresp = mk_resp(1'b1, b == 1, 32'h20 + 32'(b));
      probe();
      chk("t2_oreq0", oreq, r0);
      chk("t2_iresp1_zero", iresps[1], '0);
    end
    tick();
    ireqs[0] = '0;
    oresp = '0;
    probe();
    chk("t2_gap", oreq.valid, 1'b0);
    chk("t2_prio1", dut.prio, 1'b1);
    tick();
    oresp = mk_resp(1'b1, 1'b1, 32'h55);
    probe();
    chk("t2_oreq1", oreq, r1);
    chk("t2_iresp1", iresps[1], oresp);
    chk("t2_iresp0_zero", iresps[0], '0);
    tick();
    ireqs[1] = '0;
    oresp = '0;
    exp_cnt1++;
    probe();
    chk("t2_prio0", dut.prio, 1'b0);

    // DCache write with toggling ready, ICache waiting
    tick();
    r1 = mk_req(1'b1, 32'h4000, 8'd3);
    ireqs[1] = r1;
    probe();
    nrdy = 0;
    r0 = mk_req(1'b0, 32'h5000, 8'd0);
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) ireqs[0] = r0;
      oresp = mk_resp(c % 2 == 0, c >= 5, 32'h40 + 32'(c));
      probe();
      chk("t3_oreq1", oreq, r1);
      chk("t3_iresp1", iresps[1], oresp);
      chk("t3_iresp0_zero", iresps[0], '0);
      if (iresps[1].ready) nrdy++;
    end
    chk("t3_handshakes", nrdy, 4);
    tick();
    ireqs[1] = '0;
    oresp = '0;
    exp_cnt1++;
    probe();
    chk("t3_gap", oreq.valid, 1'b0);
    chk("t3_prio", dut.prio, 1'b0);
    tick();
    oresp = mk_resp(1'b1, 1'b1, 32'h66);
    probe();
    chk("t3_oreq0", oreq, r0);
    tick();
    ireqs[0] = '0;
    oresp = '0;
    exp_cnt0++;
    probe();
    chk("t3_prio_end", dut.prio, 1'b1);
`ifdef CBUS_ARB_STATS_EN
    chk("t3_cnt0", grant_cnt[0], exp_cnt0);
    chk("t3_cnt1", grant_cnt[1], exp_cnt1);
`endif

    // ICache aborts mid-burst
    tick();
    r0 = mk_req(1'b0, 32'h6000, 8'd3);
    ireqs[0] = r0;
    probe();
    tick();
    oresp = mk_resp(1'b1, 1'b0, 32'h77);
    probe();
    chk("t4_oreq0", oreq, r0);
    tick();
    ireqs[0] = '0;
    oresp = '0;
    probe();
    chk("t4_drop", oreq.valid, 1'b0);
    tick();
    r1 = mk_req(1'b1, 32'h7000, 8'd0);
    ireqs[1] = r1;
    probe();
    chk("t4_state", dut.state, IDLE);
    chk("t4_prio", dut.prio, 1'b1);
`ifdef CBUS_ARB_STATS_EN
    chk("t4_cnt0", grant_cnt[0], exp_cnt0);
`endif
    tick();
    oresp = mk_resp(1'b1, 1'b1, 32'h88);
    probe();
    chk("t4_oreq1", oreq, r1);
    tick();
    ireqs[1] = '0;
    oresp = '0;
    exp_cnt1++;
    probe();
    chk("t4_prio_end", dut.prio, 1'b0);
`ifdef CBUS_ARB_STATS_EN
    chk("t4_cnt1", grant_cnt[1], 32'd3);
`endif

    // Reset at beat 2 of an 8-beat burst
    tick();
    r0 = mk_req(1'b0, 32'h8000, 8'd7);
    ireqs[0] = r0;
    probe();
    tick();
    oresp = mk_resp(1'b1, 1'b0, 32'h91);
    probe();
    chk("t5_oreq0", oreq, r0);
    tick();
    oresp = mk_resp(1'b1, 1'b0, 32'h92);
    #1;
    reset = 1'b1;
    probe();
    chk("t5_oreq_rst", oreq, '0);
    chk("t5_iresps_rst", iresps, '0);
    chk("t5_state_rst", dut.state, IDLE);
    chk("t5_prio_rst", dut.prio, 1'b0);
`ifdef CBUS_ARB_STATS_EN
    chk("t5_cnt_rst", grant_cnt, '0);
`endif
    ireqs = '0;
    oresp = '0;
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    tick();
    tick();
    reset = 1'b0;
    r1 = mk_req(1'b1, 32'h9000, 8'd0);
    ireqs[1] = r1;
    probe();
    chk("t5_no_comb", oreq.valid, 1'b0);
    tick();
    oresp = mk_resp(1'b1, 1'b1, 32'haa);
    probe();
    chk("t5_oreq1", oreq, r1);
    chk("t5_iresp1", iresps[1], oresp);
    tick();
    ireqs[1] = '0;
    oresp = '0;
    exp_cnt1++;
    probe();
    chk("t5_idle", oreq.valid, 1'b0);
    chk("t5_prio_end", dut.prio, 1'b0);
`ifdef CBUS_ARB_STATS_EN
    chk("t5_cnt1", grant_cnt[1], exp_cnt1);
`endif

    done_flag = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
